// File: rtl/frame_serializer.sv
// Parallel-to-serial frame source: LSB-first data bits, optional parity bit,
// inter-frame gap and a wrapping count of completed frames.
module frame_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned    BW      = $clog2(DATA_W);
  localparam logic [BW-1:0]  BIT_END = BW'(DATA_W - 1);
  localparam logic [BW-1:0]  BIT_ONE = BW'(1);
  localparam logic [3:0]     GAP_END = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic           HAS_PAR = (PARITY_EN != 0);
  localparam logic           HAS_GAP = (GAP_CYCLES != 0);
  localparam logic           PAR_INV = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par, par_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              out_nxt, valid_nxt, last_nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      par       <= par_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      bit_out   <= out_nxt;
      bit_valid <= valid_nxt;
      bit_last  <= last_nxt;
      if (bit_last) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered, so each bit is prepared one edge ahead: data bit 0
  // leaves on the accepting edge and shreg holds only the bits still to go.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    par_nxt     = par;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    out_nxt     = 1'b0;
    valid_nxt   = 1'b0;
    last_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt   = SHIFT;
          shreg_nxt   = in_data >> 1;
          par_nxt     = ^in_data ^ PAR_INV;
          bit_cnt_nxt = '0;
          out_nxt     = in_data[0];
          valid_nxt   = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt != BIT_END) begin
          bit_cnt_nxt = bit_cnt + BIT_ONE;
          shreg_nxt   = shreg >> 1;
          out_nxt     = shreg[0];
          valid_nxt   = 1'b1;
          last_nxt    = !HAS_PAR && (bit_cnt == BIT_END - BIT_ONE);
        end else begin
          bit_cnt_nxt = '0;
          gap_cnt_nxt = '0;
          if (HAS_PAR) begin
            state_nxt = PARITY;
            out_nxt   = par;
            valid_nxt = 1'b1;
            last_nxt  = 1'b1;
          end else if (HAS_GAP) begin
            state_nxt = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      PARITY: begin
        gap_cnt_nxt = '0;
        state_nxt   = HAS_GAP ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_END) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt + 4'd1;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboarded bench for frame_serializer: three instances cover the default
// configuration, no-parity/no-gap, and odd parity with a 4-bit frame counter.
module tb_frame_serializer;

  localparam logic [2:0] PE  = 3'b101;
  localparam logic [2:0] ODD = 3'b100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data [3];
  logic [2:0]       in_valid;
  logic [2:0]       rdy, bo, bv, bl, bz;
  logic [2:0][15:0] fcnt;

  logic [1:0]       sb [3][$];
  logic [2:0]       acc;
  int               n_chk = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               hs_cyc;
  int               t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned GP = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int unsigned CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] cnt;
    frame_serializer #(
      .DATA_W    (8),
      .PARITY_EN (PE[g]),
      .ODD_PARITY(ODD[g]),
      .GAP_CYCLES(GP),
      .CNT_W     (CW)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (rdy[g]),
      .bit_out  (bo[g]),
      .bit_valid(bv[g]),
      .bit_last (bl[g]),
      .busy     (bz[g]),
      .frame_cnt(cnt)
    );
    assign fcnt[g] = 16'(cnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(rdy[d]), 1);
  endtask

  // Waits for in_ready, handshakes one word and loads the expected bit stream.
  task automatic send(input int d, input logic [7:0] w, input bit hold);
    wait_idle(d);
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    @(posedge clk);
    hs_cyc = cyc;
    for (int i = 0; i < 8; i++) sb[d].push_back({(PE[d] == 1'b0) && (i == 7), w[i]});
    if (PE[d]) sb[d].push_back({1'b1, ^w ^ ODD[d]});
    #1;
    if (!hold) in_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) acc[g] <= 1'b0;
      else if (bv[g]) begin
        if (sb[g].size() == 0) check("sb_extra", 1, 0);
        else begin
          e = sb[g].pop_front();
          check("bit", 32'(bo[g]), 32'(e[0]));
          check("last", 32'(bl[g]), 32'(e[1]));
        end
        if (bl[g]) begin
          if (PE[g]) check("par_track", 32'(acc[g] ^ bo[g]), 32'(ODD[g]));
          acc[g] <= 1'b0;
        end else acc[g] <= acc[g] ^ bo[g];
      end else if (bo[g] || bl[g]) check("idle_out", 32'({bo[g], bl[g]}), 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    for (int g = 0; g < 3; g++) in_data[g] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_outs", 32'({bo[g], bv[g], bl[g], bz[g]}), 0);
      check("rst_cnt", 32'(fcnt[g]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(rdy), 32'h7);

    // 0xA5 with exact cycle-by-cycle timing around the frame
    send(0, 8'hA5, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("a5_ready", 32'(rdy[0]), 32'(k == 11));
      check("a5_busy", 32'(bz[0]), 32'(k != 11));
      check("a5_valid", 32'(bv[0]), 32'(k <= 9));
      check("a5_last", 32'(bl[0]), 32'(k == 9));
      check("a5_cnt", 32'(fcnt[0]), 32'(k >= 10));
    end

    send(0, 8'h07, 1'b0);
    wait_idle(0);
    check("x07_cnt", 32'(fcnt[0]), 2);

    // in_valid held; in_data altered mid-frame must not affect the first word
    send(0, 8'h00, 1'b1);
    t0 = hs_cyc;
    in_data[0] = 8'hFF;
    send(0, 8'hFF, 1'b0);
    check("b2b_period", 32'(hs_cyc - t0), 11);
    wait_idle(0);
    check("b2b_cnt", 32'(fcnt[0]), 4);

    // reset during data bit 4 aborts the frame
    send(0, 8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({bo[0], bv[0], bl[0], bz[0]}), 0);
    check("midrst_cnt", 32'(fcnt[0]), 0);
    sb[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(rdy[0]), 1);
    send(0, 8'h81, 1'b0);
    wait_idle(0);
    check("x81_cnt", 32'(fcnt[0]), 1);

    // no parity, no gap: last on data bit 7, period 9
    send(1, 8'h5A, 1'b1);
    t0 = hs_cyc;
    send(1, 8'hC3, 1'b0);
    check("np_period", 32'(hs_cyc - t0), 9);
    wait_idle(1);
    check("np_cnt", 32'(fcnt[1]), 2);

    // odd parity, gap 2, 4-bit counter wrap
    send(2, 8'h07, 1'b1);
    t0 = hs_cyc;
    send(2, 8'h07, 1'b0);
    check("odd_period", 32'(hs_cyc - t0), 12);
    wait_idle(2);
    check("odd_cnt", 32'(fcnt[2]), 2);
    for (int k = 3; k <= 16; k++) begin
      send(2, 8'($urandom), 1'b0);
      wait_idle(2);
      check("cnt4", 32'(fcnt[2]), 32'(k % 16));
    end

    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) check("sb_drain", 32'(sb[g].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Parallel-to-serial frame source that feeds the serial parity-tracking stage. Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, with a qualifying strobe. It optionally appends a parity bit so that a downstream parity tracker returns to the even state after every good frame. An inter-frame gap is inserted after each frame, and completed frames are counted.

## Interface
- DATA_W, 8: word width; legal range 2..32.
- PARITY_EN, 1: 1 appends a parity bit after the data bits; 0 means no parity bit.
- ODD_PARITY, 0: 0 makes the total count of ones (data + parity) even; 1 makes it odd.
- GAP_CYCLES, 1: idle cycles after the last bit of a frame; legal range 0..15.
- CNT_W, 16: width of frame_cnt.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_W  word to send; sampled only on handshake.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; high only in IDLE.
- bit_out  out  1  serial bit; 0 whenever bit_valid=0.
- bit_valid  out  1  bit_out carries a frame bit this cycle.
- bit_last  out  1  final bit of the frame (parity bit, or data MSB if PARITY_EN=0).
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: DATA_W cycles; emits shreg[0] and shifts right.
  - PARITY: 1 cycle; emits the parity bit.
  - GAP: GAP_CYCLES cycles; bit_valid=0.
- Transitions:
  - IDLE→SHIFT on in_valid && in_ready. The word is latched into shreg. Parity is computed from the latched word: ^in_data ^ ODD_PARITY.
  - SHIFT→PARITY after DATA_W bits when PARITY_EN=1.
  - SHIFT→GAP after DATA_W bits when PARITY_EN=0 and GAP_CYCLES>0; SHIFT→IDLE when PARITY_EN=0 and GAP_CYCLES=0.
  - PARITY→GAP when GAP_CYCLES>0; PARITY→IDLE when GAP_CYCLES=0.
  - GAP→IDLE when the gap counter expires.
- in_valid and in_data are ignored outside IDLE. No word is ever dropped or duplicated.
- Bit counter: sized for DATA_W; counts 0..DATA_W-1 in SHIFT and is cleared on entry.
- frame_cnt increments by 1 in the cycle after bit_last is presented. It wraps from all-ones to 0.
- Reset values (applied immediately on rst_n falling, regardless of state):
  - state=IDLE, so in_ready=1 once rst_n is high.
  - bit_out=0, bit_valid=0, bit_last=0, busy=0, frame_cnt=0.
  - shreg and counters cleared.
- Reset mid-frame aborts the frame. No bit_last is issued and frame_cnt does not increment. The next accepted word produces a complete, correct frame.

## Timing
- bit_out, bit_valid and bit_last are registered. in_ready and busy decode directly from state.
- Handshake at rising edge T (IDLE, in_valid=1):
  - Data bit i appears in cycle T+1+i, for i = 0..DATA_W-1.
  - Parity bit appears in cycle T+1+DATA_W.
  - bit_valid is continuous, with no bubbles within a frame.
- in_ready goes low from T+1 and returns high 1+DATA_W+PARITY_EN+GAP_CYCLES cycles after T.
- Frame period with in_valid held high: 1+DATA_W+PARITY_EN+GAP_CYCLES cycles. With the defaults this is 11.
- bit_last is high for exactly one cycle per frame, coincident with bit_valid.

## Test plan
- Defaults, send 0xA5 at T → bits 1,0,1,0,0,1,0,1 in T+1..T+8. Parity 0 with bit_last at T+9. bit_valid=0 at T+10. in_ready=1 at T+11. frame_cnt=1.
- Defaults, send 0x07 → parity bit 1. A downstream parity tracker fed bit_out/bit_valid reads even after the frame. With ODD_PARITY=1 the same word gives parity 0.
- in_valid held high with 0x00 then 0xFF → second handshake exactly 11 cycles after the first. Second frame is 8 ones then parity 0. in_data changes during the frame have no effect.
- rst_n pulsed low during data bit 4 of 0x3C → all outputs 0 immediately and frame_cnt stays 0. After release, 0x81 produces 1,0,0,0,0,0,0,1, parity 0; frame_cnt=1.
- PARITY_EN=0, GAP_CYCLES=0 → bit_last on data bit 7. Back-to-back frame period is 9 cycles.
- CNT_W=4, send 16 frames → frame_cnt reads 15 after frame 15 and 0 after frame 16.
